// File: rtl/systolic_pkg.sv
// systolic_pkg: drain state encodings and index-width helper shared by the drain RTL and benches
package systolic_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drain_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/systolic_drain_if.sv
// systolic_drain_if: valid/ready result stream leaving the drain
interface systolic_drain_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic              send_val;
  logic              send_rdy;
  logic [DATA_W-1:0] send_msg;
  logic [IDX_W-1:0]  send_idx;
  logic              send_last;
  modport master (output send_val, send_msg, send_idx, send_last, input send_rdy);
  modport slave  (input send_val, send_msg, send_idx, send_last, output send_rdy);
endinterface

// File: rtl/systolic_snapshot_reg.sv
// systolic_snapshot_reg: freezes the accumulator array on capture and serves one entry by index
module systolic_snapshot_reg
  import systolic_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int DATA_W = 32,
  localparam int N     = SIZE * SIZE,
  localparam int IW    = idx_w(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture,
  input  logic [N*DATA_W-1:0] data_in,
  input  logic [IW-1:0]       rd_idx,
  output logic [DATA_W-1:0]   rd_data
);
  logic [DATA_W-1:0] bank_q [N];
  // bank loads every entry at once so later array activity cannot leak into the drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) bank_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N; i++) bank_q[i] <= data_in[i*DATA_W +: DATA_W];
    end
  end
  assign rd_data = bank_q[rd_idx];
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: snapshots the PE accumulators and streams them out row-major over valid/ready
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int DATA_W = 32,
  localparam int N     = SIZE * SIZE,
  localparam int IW    = idx_w(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_out_rdy,
  input  logic [N*DATA_W-1:0] acc_data,
  input  logic                restart,
  output logic                send_val,
  input  logic                send_rdy,
  output logic [DATA_W-1:0]   send_msg,
  output logic [IW-1:0]       send_idx,
  output logic                send_last,
  output logic                done
);
  drain_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic val_q, last_q, done_q;
  logic capture, xfer, at_end;
  // restart outranks capture and transfer; index only moves on an accepted word
  always_comb begin
    at_end  = idx_q == IW'(N - 1);
    xfer    = val_q && send_rdy;
    capture = state_q == IDLE && ctrl_out_rdy && !restart;
    state_d = restart ? IDLE : capture ? SEND : (xfer && at_end) ? DONE : state_q;
    idx_d   = (restart || capture) ? '0 : (xfer && !at_end) ? idx_q + IW'(1) : idx_q;
  end
  // state, index and flags all registered so outputs never glitch and clear on reset at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= state_d == SEND;
      last_q  <= state_d == SEND && idx_d == IW'(N - 1);
      done_q  <= state_d == DONE;
    end
  end
  systolic_snapshot_reg #(.SIZE(SIZE), .DATA_W(DATA_W)) u_snap (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .data_in (acc_data),
    .rd_idx  (idx_q),
    .rd_data (send_msg)
  );
  assign send_val  = val_q;
  assign send_idx  = idx_q;
  assign send_last = last_q;
  assign done      = done_q;
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_systolic_drain;
  typedef struct {
    logic [7:0] msg;
    logic [1:0] idx;
    logic       last;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_out_rdy;
  logic        restart;
  logic [31:0] acc_data;
  logic        done;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic        held = 1'b0;
  logic [7:0]  hmsg;
  logic [1:0]  hidx;
  logic [3:0]  pat = 4'b1001;
  systolic_drain_if #(.DATA_W(8), .IDX_W(2)) dif ();
  systolic_drain #(.SIZE(2), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_out_rdy (ctrl_out_rdy),
    .acc_data     (acc_data),
    .restart      (restart),
    .send_val     (dif.send_val),
    .send_rdy     (dif.send_rdy),
    .send_msg     (dif.send_msg),
    .send_idx     (dif.send_idx),
    .send_last    (dif.send_last),
    .done         (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load(input logic [7:0] w0, w1, w2, w3);
    acc_data = {w3, w2, w1, w0};
    exp_q.push_back('{w0, 2'd0, 1'b0});
    exp_q.push_back('{w1, 2'd1, 1'b0});
    exp_q.push_back('{w2, 2'd2, 1'b0});
    exp_q.push_back('{w3, 2'd3, 1'b1});
  endtask
  task automatic capture();
    ctrl_out_rdy = 1'b1;
    step();
    ctrl_out_rdy = 1'b0;
  endtask
  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (held && dif.send_val) begin
        chk("stall_msg", dif.send_msg, hmsg);
        chk("stall_idx", dif.send_idx, hidx);
      end
      if (dif.send_val && dif.send_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got idx %0d msg %0h want none", dif.send_idx, dif.send_msg);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_msg", dif.send_msg, e.msg);
          chk("word_idx", dif.send_idx, e.idx);
          chk("word_last", dif.send_last, e.last);
        end
      end
      held = dif.send_val && !dif.send_rdy;
      hmsg = dif.send_msg;
      hidx = dif.send_idx;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    ctrl_out_rdy = 1'b0;
    restart = 1'b0;
    acc_data = '0;
    dif.send_rdy = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_val", dif.send_val, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", dif.send_idx, 0);
    chk("rst_msg", dif.send_msg, 0);
    chk("rst_last", dif.send_last, 0);
    step(2);
    rst = 1'b1;
    step();
    load(8'h11, 8'h22, 8'h33, 8'h44);
    dif.send_rdy = 1'b1;
    capture();
    chk("first_val", dif.send_val, 1);
    chk("first_idx", dif.send_idx, 0);
    step(4);
    chk("burst_done", done, 1);
    chk("burst_val_off", dif.send_val, 0);
    chk("burst_drained", exp_q.size(), 0);
    ctrl_out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("done_hold", done, 1);
      chk("done_no_val", dif.send_val, 0);
    end
    ctrl_out_rdy = 1'b0;
    do_restart();
    chk("restart_done_clr", done, 0);
    chk("restart_val", dif.send_val, 0);
    load(8'ha1, 8'hb2, 8'hc3, 8'hd4);
    dif.send_rdy = 1'b0;
    capture();
    acc_data = '1;
    for (int k = 0; k < 40 && !done; k++) begin
      dif.send_rdy = pat[k%4];
      step();
    end
    chk("stall_done", done, 1);
    chk("stall_drained", exp_q.size(), 0);
    do_restart();
    load(8'h01, 8'h02, 8'h03, 8'h04);
    dif.send_rdy = 1'b1;
    capture();
    step(2);
    dif.send_rdy = 1'b0;
    exp_q.delete();
    do_restart();
    chk("abort_val", dif.send_val, 0);
    chk("abort_idx", dif.send_idx, 0);
    step(2);
    chk("abort_wait", dif.send_val, 0);
    load(8'h05, 8'h06, 8'h07, 8'h08);
    dif.send_rdy = 1'b1;
    capture();
    chk("rearm_idx", dif.send_idx, 0);
    chk("rearm_val", dif.send_val, 1);
    step(4);
    chk("rearm_done", done, 1);
    do_restart();
    load(8'h09, 8'h0a, 8'h0b, 8'h0c);
    dif.send_rdy = 1'b0;
    capture();
    #2 rst = 1'b0;
    #1;
    chk("arst_val", dif.send_val, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", dif.send_idx, 0);
    chk("arst_msg", dif.send_msg, 0);
    exp_q.delete();
    step(2);
    rst = 1'b1;
    dif.send_rdy = 1'b1;
    step(3);
    chk("post_rst_idle", dif.send_val, 0);
    load(8'h5a, 8'h6b, 8'h7c, 8'h8d);
    capture();
    step(4);
    chk("post_rst_done", done, 1);
    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
